// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional feature macro UART_ARB_TIMEOUT_EN adds a per-byte tx_done watchdog with sticky err_timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          arb_busy,
  output logic                          err_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_owner;
  logic [IW-1:0]           r_rr_ptr;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_ack;
  logic                    r_tx_start;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_last;
  logic [7:0]              r_burst_cnt;

  logic                    w_found;
  logic [IW-1:0]           w_pick;
  logic [IW-1:0]           w_owner_nxt;
  logic                    w_req_g;
  logic                    w_last_g;
  logic [DATA_WIDTH-1:0]   w_data_g;
  logic [7:0]              w_burst_inc;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]           r_to_cnt;
  logic                    r_err;
`endif

  // First asserted requester at or after r_rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[IW'((32'(r_rr_ptr) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_pick  = IW'((32'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_data_g = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_owner == IW'(k)) begin
        w_req_g  = req[k];
        w_last_g = req_last[k];
        w_data_g = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_owner_nxt = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_burst_inc = r_burst_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner     <= w_pick;
            r_grant     <= NUM_REQ'(1) << w_pick;
            r_burst_cnt <= '0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (!w_req_g) begin
            r_grant  <= '0;
            r_rr_ptr <= w_owner_nxt;
            r_state  <= IDLE;
          end else if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_ack      <= r_grant;
            r_tx_data  <= w_data_g;
            r_last     <= w_last_g;
            r_state    <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            r_burst_cnt <= w_burst_inc;
            if (r_last || w_burst_inc == 8'(MAX_BURST)) begin
              r_grant  <= '0;
              r_rr_ptr <= w_owner_nxt;
              r_state  <= IDLE;
            end else begin
              r_state <= LOAD;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err    <= 1'b1;
            r_grant  <= '0;
            r_rr_ptr <= w_owner_nxt;
            r_state  <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign grant    = r_grant;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign arb_busy = (r_state != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requesters, a delay-based transmitter model,
// and a message-level reference model predicting the transmitted (requester, byte) sequence.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TO = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    grant;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy = 1'b0;
  logic             tx_done = 1'b0;
  logic             arb_busy;
  logic             err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  // Requester byte queues: bit 8 = last-of-message
  logic [8:0] qbuf [NR][64];
  int qrd [NR];
  int qwr [NR];

  int          exp_req [$];
  logic [7:0]  exp_dat [$];
  int          obs_req [$];
  logic [7:0]  obs_dat [$];
  int          m_rr = 0;

  int   tx_delay = 4;
  int   tx_cnt = 0;
  logic tx_model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic hold_done = 1'b0;

  logic [NR-1:0] s_grant, s_ack;
  logic          s_tx_start, s_arb_busy, s_err;
  logic [DW-1:0] s_tx_data;
  int            prot_viol = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qbuf[r][qwr[r] % 64] = {l, d};
    qwr[r]++;
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      if (qrd[i] != qwr[i]) begin
        e = qbuf[i][qrd[i] % 64];
        req[i] = 1'b1;
        req_data[i*DW +: DW] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
    tx_busy = tx_model_busy | force_busy;
  endtask

  // One clock: sample outputs at negedge, advance requester/transmitter models, drive inputs.
  task automatic tick();
    @(negedge clk);
    s_grant = grant; s_ack = ack; s_tx_start = tx_start; s_tx_data = tx_data;
    s_arb_busy = arb_busy; s_err = err_timeout;
    if ((s_tx_start !== (s_ack != 0)) || ($countones(s_ack) > 1) || ((s_ack & ~s_grant) != 0))
      prot_viol++;
    if (s_tx_start) begin
      for (int i = 0; i < NR; i++) begin
        if (s_ack[i]) begin
          obs_req.push_back(i);
          obs_dat.push_back(s_tx_data);
          if (qrd[i] != qwr[i]) qrd[i]++;
        end
      end
    end
    tx_done = 1'b0;
    if (s_tx_start && !hold_done) begin
      tx_model_busy = 1'b1;
      tx_cnt = tx_delay;
    end else if (tx_model_busy) begin
      tx_cnt--;
      if (tx_cnt <= 0) begin
        tx_done = 1'b1;
        tx_model_busy = 1'b0;
      end
    end
    drive();
  endtask

  // Reference: whole messages (split at MB bytes) served round-robin from the pointer.
  task automatic build_expected();
    int rd [NR];
    int g, n, c;
    logic [8:0] e;
    bit fin;
    for (int i = 0; i < NR; i++) rd[i] = qrd[i];
    exp_req.delete(); exp_dat.delete();
    obs_req.delete(); obs_dat.delete();
    prot_viol = 0;
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_rr + k) % NR;
        if (g < 0 && rd[c] != qwr[c]) g = c;
      end
      if (g < 0) break;
      n = 0;
      fin = 1'b0;
      while (!fin) begin
        e = qbuf[g][rd[g] % 64];
        rd[g]++;
        n++;
        exp_req.push_back(g);
        exp_dat.push_back(e[7:0]);
        fin = e[8] || (n == MB) || (rd[g] == qwr[g]);
      end
      m_rr = (g + 1) % NR;
    end
  endtask

  task automatic collect(input int budget, output bit timed_out);
    int b = 0;
    bit fin = 1'b0;
    while (!fin && b < budget) begin
      tick();
      b++;
      fin = (obs_req.size() >= exp_req.size()) && !s_arb_busy && !tx_model_busy && !tx_done;
    end
    timed_out = !fin;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) qrd[i] = qwr[i];
    m_rr = 0;
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive();
    tick(); tick();
    n_vec++; if (s_grant !== '0) begin n_err++; $display("FAIL reset_grant got %b want 0", s_grant); end
    n_vec++; if (s_ack !== '0) begin n_err++; $display("FAIL reset_ack got %b want 0", s_ack); end
    n_vec++; if (s_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", s_tx_start); end
    n_vec++; if (s_tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data got %h want 00", s_tx_data); end
    n_vec++; if (s_arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_arb_busy got %b want 0", s_arb_busy); end
    n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", s_err); end
    rst_n = 1'b1;
    m_rr = 0;
  endtask

  task automatic test_single();
    int b = 0;
    tx_delay = 6;
    push(1, 8'h41, 1'b1);
    build_expected();
    drive();
    tick();
    n_vec++; if (s_grant !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b want 0010", s_grant); end
    n_vec++; if (s_tx_start !== 1'b0) begin n_err++; $display("FAIL single_early_start got %b want 0", s_tx_start); end
    tick();
    n_vec++; if (s_tx_start !== 1'b1) begin n_err++; $display("FAIL single_start got %b want 1", s_tx_start); end
    n_vec++; if (s_ack !== 4'b0010) begin n_err++; $display("FAIL single_ack got %b want 0010", s_ack); end
    n_vec++; if (s_tx_data !== 8'h41) begin n_err++; $display("FAIL single_data got %h want 41", s_tx_data); end
    while (!tx_done && b < 50) begin tick(); b++; end
    n_vec++; if (b >= 50) begin n_err++; $display("FAIL single_done_wait got timeout want tx_done"); end
    tick();
    n_vec++; if (s_grant !== '0) begin n_err++; $display("FAIL single_release got %b want 0", s_grant); end
    n_vec++; if (s_arb_busy !== 1'b0) begin n_err++; $display("FAIL single_idle got %b want 0", s_arb_busy); end
  endtask

  task automatic test_round_robin();
    int want [6] = '{0, 1, 3, 0, 1, 3};
    bit to;
    do_reset();
    tx_delay = 20;
    for (int m = 0; m < 2; m++) begin
      push(0, 8'($urandom), 1'b1);
      push(1, 8'($urandom), 1'b1);
      push(3, 8'($urandom), 1'b1);
    end
    build_expected();
    drive();
    collect(1000, to);
    n_vec++; if (to) begin n_err++; $display("FAIL rr_timeout got busy want idle"); end
    n_vec++; if (obs_req.size() !== 6) begin n_err++; $display("FAIL rr_count got %0d want 6", obs_req.size()); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= obs_req.size() || obs_req[i] !== want[i] || obs_dat[i] !== exp_dat[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d] got req%0d want req%0d", i, (i < obs_req.size()) ? obs_req[i] : -1, want[i]);
      end
    end
    n_vec++; if (prot_viol !== 0) begin n_err++; $display("FAIL rr_protocol got %0d violations want 0", prot_viol); end
  endtask

  task automatic test_message_lock();
    bit to;
    tx_delay = 5;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(2, 8'($urandom), 1'b1);
    build_expected();
    drive();
    collect(500, to);
    n_vec++; if (to) begin n_err++; $display("FAIL lock_timeout got busy want idle"); end
    n_vec++; if (obs_req.size() !== exp_req.size()) begin n_err++; $display("FAIL lock_count got %0d want %0d", obs_req.size(), exp_req.size()); end
    for (int i = 0; i < exp_req.size(); i++) begin
      n_vec++;
      if (i >= obs_req.size() || obs_req[i] !== exp_req[i] || obs_dat[i] !== exp_dat[i]) begin
        n_err++;
        $display("FAIL lock_byte[%0d] got req%0d 0x%02h want req%0d 0x%02h", i,
                 (i < obs_req.size()) ? obs_req[i] : -1, (i < obs_dat.size()) ? obs_dat[i] : 8'h00, exp_req[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_burst_limit();
    bit to;
    tx_delay = 3;
    for (int i = 0; i < 6; i++) push(0, 8'(8'h20 + i), (i == 5));
    push(1, 8'h55, 1'b1);
    build_expected();
    drive();
    collect(500, to);
    n_vec++; if (to) begin n_err++; $display("FAIL burst_timeout got busy want idle"); end
    n_vec++; if (obs_req.size() !== 7) begin n_err++; $display("FAIL burst_count got %0d want 7", obs_req.size()); end
    for (int i = 0; i < exp_req.size(); i++) begin
      n_vec++;
      if (i >= obs_req.size() || obs_req[i] !== exp_req[i] || obs_dat[i] !== exp_dat[i]) begin
        n_err++;
        $display("FAIL burst_byte[%0d] got req%0d 0x%02h want req%0d 0x%02h", i,
                 (i < obs_req.size()) ? obs_req[i] : -1, (i < obs_dat.size()) ? obs_dat[i] : 8'h00, exp_req[i], exp_dat[i]);
      end
    end
    n_vec++; if (prot_viol !== 0) begin n_err++; $display("FAIL burst_protocol got %0d violations want 0", prot_viol); end
  endtask

  task automatic test_busy_hold();
    int starts = 0;
    bit to;
    tx_delay = 4;
    push(3, 8'hC3, 1'b1);
    build_expected();
    force_busy = 1'b1;
    drive();
    tick(); tick();
    repeat (10) begin tick(); if (s_tx_start) starts++; end
    n_vec++; if (starts !== 0) begin n_err++; $display("FAIL busy_no_start got %0d starts want 0", starts); end
    n_vec++; if (s_grant !== 4'b1000) begin n_err++; $display("FAIL busy_grant got %b want 1000", s_grant); end
    force_busy = 1'b0;
    drive();
    tick();
    n_vec++; if (s_tx_start !== 1'b1) begin n_err++; $display("FAIL busy_release_start got %b want 1", s_tx_start); end
    n_vec++; if (s_tx_data !== 8'hC3) begin n_err++; $display("FAIL busy_data got %h want c3", s_tx_data); end
    collect(200, to);
    n_vec++; if (to) begin n_err++; $display("FAIL busy_timeout got busy want idle"); end
  endtask

  task automatic test_reset_mid();
    int b = 0;
    tx_delay = 20;
    push(2, 8'hA5, 1'b1);
    build_expected();
    drive();
    while (!s_tx_start && b < 20) begin tick(); b++; end
    n_vec++; if (b >= 20) begin n_err++; $display("FAIL rstmid_start got none want tx_start"); end
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_vec++; if (s_grant !== '0) begin n_err++; $display("FAIL rstmid_grant got %b want 0", s_grant); end
    n_vec++; if (s_arb_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", s_arb_busy); end
    rst_n = 1'b1;
    m_rr = 0;
    b = 0;
    while (!tx_done && b < 50) begin tick(); b++; end
    tick(); tick();
    n_vec++; if (s_arb_busy !== 1'b0 || s_grant !== '0) begin n_err++; $display("FAIL stray_done got busy=%b grant=%b want 0/0", s_arb_busy, s_grant); end
  endtask

  task automatic test_random();
    bit to;
    int nmsg, len;
    for (int round = 0; round < 4; round++) begin
      tx_delay = $urandom_range(1, 8);
      for (int r = 0; r < NR; r++) begin
        nmsg = $urandom_range(0, 2);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) push(r, 8'($urandom), (j == len - 1));
        end
      end
      build_expected();
      drive();
      collect(3000, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rand%0d_timeout got busy want idle", round); end
      n_vec++; if (obs_req.size() !== exp_req.size()) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d", round, obs_req.size(), exp_req.size()); end
      for (int i = 0; i < exp_req.size(); i++) begin
        n_vec++;
        if (i >= obs_req.size() || obs_req[i] !== exp_req[i] || obs_dat[i] !== exp_dat[i]) begin
          n_err++;
          $display("FAIL rand%0d_byte[%0d] got req%0d 0x%02h want req%0d 0x%02h", round, i,
                   (i < obs_req.size()) ? obs_req[i] : -1, (i < obs_dat.size()) ? obs_dat[i] : 8'h00, exp_req[i], exp_dat[i]);
        end
      end
      n_vec++; if (prot_viol !== 0) begin n_err++; $display("FAIL rand%0d_protocol got %0d want 0", round, prot_viol); end
`ifndef UART_ARB_TIMEOUT_EN
      n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL rand%0d_err got %b want 0", round, s_err); end
`endif
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int b = 0;
    bit to;
    do_reset();
    tx_delay = 4;
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    build_expected();
    hold_done = 1'b1;
    drive();
    while (!s_tx_start && b < 20) begin tick(); b++; end
    n_vec++; if (s_ack !== 4'b0001) begin n_err++; $display("FAIL to_first_ack got %b want 0001", s_ack); end
    repeat (TO - 1) tick();
    n_vec++; if (s_err !== 1'b0 || s_grant !== 4'b0001) begin n_err++; $display("FAIL to_early got err=%b grant=%b want 0/0001", s_err, s_grant); end
    hold_done = 1'b0;
    tick();
    n_vec++; if (s_err !== 1'b1 || s_grant !== '0) begin n_err++; $display("FAIL to_abort got err=%b grant=%b want 1/0000", s_err, s_grant); end
    b = 0;
    while (!s_tx_start && b < 20) begin tick(); b++; end
    n_vec++; if (s_ack !== 4'b0010) begin n_err++; $display("FAIL to_next_ack got %b want 0010", s_ack); end
    collect(200, to);
    n_vec++; if (s_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", s_err); end
    do_reset();
    n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL to_clear got %b want 0", s_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin qrd[i] = 0; qwr[i] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_message_lock();
    test_burst_limit();
    test_busy_hold();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
